// File: rtl/kbd_pkg.sv
// Shared constants for the keyboard character buffer: CPU register
// addresses, STATUS bit positions and the ASCII codes with special meaning.
package kbd_pkg;

  typedef enum logic [1:0] {
    KBD_A_DATA   = 2'd0,
    KBD_A_STATUS = 2'd1,
    KBD_A_COUNT  = 2'd2,
    KBD_A_RSVD   = 2'd3
  } kbd_addr_e;

  localparam int ST_IRQ  = 1;
  localparam int ST_FULL = 2;
  localparam int ST_OVF  = 3;

  localparam logic [7:0] ASCII_BS  = 8'h08;
  localparam logic [7:0] ASCII_NUL = 8'h00;

endpackage

// File: rtl/kbd_fifo_ctrl_if.sv
// Keyboard/CPU side bus of the character buffer. The master drives the
// keyboard strobe and the CPU read strobe; the slave (the controller)
// returns read data and the irq/full flags.
interface kbd_fifo_ctrl_if #(
  parameter int DW = 8
);

  logic          key_valid;
  logic [DW-1:0] key_ascii;
  logic          cpu_rd;
  logic [1:0]    cpu_addr;
  logic [DW-1:0] cpu_rdata;
  logic          irq;
  logic          full;

  modport master (
    output key_valid, key_ascii, cpu_rd, cpu_addr,
    input  cpu_rdata, irq, full
  );

  modport slave (
    input  key_valid, key_ascii, cpu_rd, cpu_addr,
    output cpu_rdata, irq, full
  );

endinterface

// File: rtl/kbd_fifo_mem.sv
// Character storage for the keyboard FIFO: DEPTH x DW register array with
// one synchronous write port and one asynchronous read port. The array has
// no reset; validity of its contents is tracked by the controller's pointers.
module kbd_fifo_mem #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];

  // Store a character at the write pointer whenever the controller accepts a push
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/kbd_fifo_ctrl.sv
// Keyboard character buffer controller: circular FIFO between the
// scancode-to-ASCII stage and the CPU, with a DATA/STATUS/COUNT register
// window. Optional feature macro: KBD_BACKSPACE_EN (a pushed 0x08 retracts
// the newest unread character instead of being stored).
module kbd_fifo_ctrl
  import kbd_pkg::*;
#(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            clr,
  kbd_fifo_ctrl_if.slave  bus
);

  localparam int          DEPTH    = 1 << AW;
  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] LP_ONE   = (AW+1)'(1);

  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;
  logic          r_ovf;
  logic [DW-1:0] r_rdata;
  logic          r_irq;
  logic          r_full;

  logic          w_pop_req;
  logic          w_status_rd;
  logic          w_not_empty;
  logic          w_full_now;
  logic          w_key_bs;
  logic          w_push_req;
  logic          w_bs_req;
  logic          w_pop;
  logic          w_push;
  logic          w_bs;
  logic          w_ovf_set;
  logic          w_ovf_nxt;
  logic [AW:0]   w_count_nxt;
  logic [AW-1:0] w_wr_ptr_nxt;
  logic [AW-1:0] w_rd_ptr_nxt;
  logic [DW-1:0] w_mem_rdata;
  logic [DW-1:0] w_status;
  logic [DW-1:0] w_rdata_nxt;

  assign w_pop_req   = bus.cpu_rd && (bus.cpu_addr == KBD_A_DATA);
  assign w_status_rd = bus.cpu_rd && (bus.cpu_addr == KBD_A_STATUS);
  assign w_not_empty = (r_count != '0);
  assign w_full_now  = (r_count == LP_DEPTH);

`ifdef KBD_BACKSPACE_EN
  assign w_key_bs = (bus.key_ascii == DW'(ASCII_BS));
`else
  assign w_key_bs = 1'b0;
`endif

  assign w_push_req = bus.key_valid && !w_key_bs;
  assign w_bs_req   = bus.key_valid && w_key_bs;

  // A pop only happens with data present; a full FIFO still accepts a push
  // when a pop frees the slot in the same cycle. A backspace needs an unread
  // character left over after any simultaneous pop, so the pop wins at count 1.
  assign w_pop     = w_pop_req && w_not_empty;
  assign w_push    = w_push_req && (!w_full_now || w_pop);
  assign w_bs      = w_bs_req && (w_pop ? (r_count > LP_ONE) : w_not_empty);
  assign w_ovf_set = w_push_req && w_full_now && !w_pop;

  // Overflow flag: sticky, cleared by a STATUS read, but a new overflow wins
  always_comb begin
    w_ovf_nxt = r_ovf;
    if (w_ovf_set) begin
      w_ovf_nxt = 1'b1;
    end else if (w_status_rd) begin
      w_ovf_nxt = 1'b0;
    end
  end

  // Next pointers and count from the accepted push, pop and backspace
  always_comb begin
    w_count_nxt  = r_count;
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    if (w_push) begin
      w_count_nxt  = w_count_nxt + LP_ONE;
      w_wr_ptr_nxt = r_wr_ptr + AW'(1);
    end
    if (w_bs) begin
      w_count_nxt  = w_count_nxt - LP_ONE;
      w_wr_ptr_nxt = r_wr_ptr - AW'(1);
    end
    if (w_pop) begin
      w_count_nxt  = w_count_nxt - LP_ONE;
      w_rd_ptr_nxt = r_rd_ptr + AW'(1);
    end
  end

  // CPU read mux; status shows the flags as they stood before this edge
  always_comb begin
    w_status         = '0;
    w_status[ST_IRQ]  = r_irq;
    w_status[ST_FULL] = r_full;
    w_status[ST_OVF]  = r_ovf;
    w_rdata_nxt      = r_rdata;
    if (bus.cpu_rd) begin
      case (bus.cpu_addr)
        KBD_A_DATA:   w_rdata_nxt = w_pop ? w_mem_rdata : DW'(ASCII_NUL);
        KBD_A_STATUS: w_rdata_nxt = w_status;
        KBD_A_COUNT:  w_rdata_nxt = DW'(r_count);
        default:      w_rdata_nxt = DW'(ASCII_NUL);
      endcase
    end
  end

  // State registers; irq/full are registered from the post-edge count
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_rdata  <= '0;
      r_irq    <= 1'b0;
      r_full   <= 1'b0;
    end else begin
      r_rd_ptr <= w_rd_ptr_nxt;
      r_wr_ptr <= w_wr_ptr_nxt;
      r_count  <= w_count_nxt;
      r_ovf    <= w_ovf_nxt;
      r_rdata  <= w_rdata_nxt;
      r_irq    <= (w_count_nxt != '0);
      r_full   <= (w_count_nxt == LP_DEPTH);
    end
  end

  kbd_fifo_mem #(
    .AW (AW),
    .DW (DW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.key_ascii),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_mem_rdata)
  );

  assign bus.cpu_rdata = r_rdata;
  assign bus.irq       = r_irq;
  assign bus.full      = r_full;

endmodule

// File: tb/tb_kbd_fifo_ctrl.sv
// Directed testbench for the keyboard character buffer controller.
// Honours KBD_BACKSPACE_EN the same way as the design.
module tb_kbd_fifo_ctrl;
  import kbd_pkg::*;

  logic clk;
  logic clr;
  int   checks;
  int   errors;

  kbd_fifo_ctrl_if #(.DW(8)) kbdIf ();

  kbd_fifo_ctrl #(
    .AW (4),
    .DW (8)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (kbdIf)
  );

  // Free-running 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One bus cycle: drive on the falling edge, sample 1 unit after the rising edge
  task automatic applyStimulus(input logic kv, input logic [7:0] ka,
                               input logic rd, input logic [1:0] addr);
    @(negedge clk);
    kbdIf.key_valid = kv;
    kbdIf.key_ascii = ka;
    kbdIf.cpu_rd    = rd;
    kbdIf.cpu_addr  = addr;
    @(posedge clk);
    #1;
    kbdIf.key_valid = 1'b0;
    kbdIf.cpu_rd    = 1'b0;
  endtask

  task automatic pushKey(input logic [7:0] ch);
    applyStimulus(1'b1, ch, 1'b0, 2'd0);
  endtask

  task automatic readReg(input logic [1:0] addr);
    applyStimulus(1'b0, 8'h00, 1'b1, addr);
  endtask

  task automatic test_reset();
    clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (kbdIf.cpu_rdata !== 8'h00 || kbdIf.irq !== 1'b0 || kbdIf.full !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state rdata=%h irq=%b full=%b required 00/0/0",
               kbdIf.cpu_rdata, kbdIf.irq, kbdIf.full);
    end
    @(negedge clk);
    clr = 1'b0;
    readReg(2'd0);
    checks++;
    if (kbdIf.cpu_rdata !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_pop got %h required 00", kbdIf.cpu_rdata);
    end
    checks++;
    if (kbdIf.irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_irq got %b required 0", kbdIf.irq);
    end
    readReg(2'd2);
    checks++;
    if (kbdIf.cpu_rdata !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_count got %h required 00", kbdIf.cpu_rdata);
    end
  endtask

  task automatic test_push_pop();
    logic [7:0] expData [3];
    logic       expIrq  [3];
    expData = '{8'h41, 8'h42, 8'h00};
    expIrq  = '{1'b1, 1'b0, 1'b0};
    pushKey(8'h41);
    pushKey(8'h42);
    checks++;
    if (kbdIf.irq !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pp_irq_after_push got %b required 1", kbdIf.irq);
    end
    for (int i = 0; i < 3; i++) begin
      readReg(2'd0);
      checks++;
      if (kbdIf.cpu_rdata !== expData[i] || kbdIf.irq !== expIrq[i]) begin
        errors++;
        $display("[TB] FAIL pp_pop%0d got %h/irq=%b required %h/irq=%b",
                 i, kbdIf.cpu_rdata, kbdIf.irq, expData[i], expIrq[i]);
      end
    end
  endtask

  task automatic test_full_overflow();
    logic [7:0] expStat [6];
    expStat = '{8'h0E, 8'h10, 8'h06, 8'h06, 8'h0E, 8'h06};
    for (int i = 0; i < 16; i++) begin
      pushKey(8'h30 + 8'(i));
    end
    checks++;
    if (kbdIf.full !== 1'b1 || kbdIf.irq !== 1'b1) begin
      errors++;
      $display("[TB] FAIL full_flag full=%b irq=%b required 1/1", kbdIf.full, kbdIf.irq);
    end
    pushKey(8'h5A);
    readReg(2'd1);
    readReg(2'd2);
    readReg(2'd1);
    // Overflow together with a STATUS read: old value returned, flag kept
    applyStimulus(1'b1, 8'h59, 1'b1, 2'd1);
    readReg(2'd1);
    readReg(2'd1);
    // Reads above were issued back to back; recheck by replaying is not needed,
    // the last value must be the final clear
    checks++;
    if (kbdIf.cpu_rdata !== expStat[5]) begin
      errors++;
      $display("[TB] FAIL full_status_final got %h required %h", kbdIf.cpu_rdata, expStat[5]);
    end
    for (int i = 0; i < 16; i++) begin
      readReg(2'd0);
      checks++;
      if (kbdIf.cpu_rdata !== 8'h30 + 8'(i)) begin
        errors++;
        $display("[TB] FAIL full_drain%0d got %h required %h", i, kbdIf.cpu_rdata, 8'h30 + 8'(i));
      end
    end
    checks++;
    if (kbdIf.full !== 1'b0 || kbdIf.irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_drained full=%b irq=%b required 0/0", kbdIf.full, kbdIf.irq);
    end
  endtask

  task automatic test_status_sequence();
    logic [7:0] expStat [6];
    logic [1:0] addr    [6];
    logic       kv      [6];
    expStat = '{8'h0E, 8'h10, 8'h06, 8'h06, 8'h0E, 8'h06};
    addr    = '{2'd1, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1};
    kv      = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 16; i++) begin
      pushKey(8'h20 + 8'(i));
    end
    pushKey(8'h5A);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(kv[i], 8'h59, 1'b1, addr[i]);
      checks++;
      if (kbdIf.cpu_rdata !== expStat[i]) begin
        errors++;
        $display("[TB] FAIL status_seq%0d got %h required %h", i, kbdIf.cpu_rdata, expStat[i]);
      end
    end
    for (int i = 0; i < 16; i++) begin
      readReg(2'd0);
      checks++;
      if (kbdIf.cpu_rdata !== 8'h20 + 8'(i)) begin
        errors++;
        $display("[TB] FAIL status_drain%0d got %h required %h", i, kbdIf.cpu_rdata, 8'h20 + 8'(i));
      end
    end
    readReg(2'd0);
    checks++;
    if (kbdIf.cpu_rdata !== 8'h00) begin
      errors++;
      $display("[TB] FAIL status_no_z got %h required 00", kbdIf.cpu_rdata);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 16; i++) begin
      pushKey(8'h40 + 8'(i));
    end
    applyStimulus(1'b1, 8'h71, 1'b1, 2'd0);
    checks++;
    if (kbdIf.cpu_rdata !== 8'h40 || kbdIf.full !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sim_full_pop got %h/full=%b required 40/1", kbdIf.cpu_rdata, kbdIf.full);
    end
    readReg(2'd1);
    checks++;
    if (kbdIf.cpu_rdata !== 8'h06) begin
      errors++;
      $display("[TB] FAIL sim_no_ovf got %h required 06", kbdIf.cpu_rdata);
    end
    readReg(2'd2);
    checks++;
    if (kbdIf.cpu_rdata !== 8'h10) begin
      errors++;
      $display("[TB] FAIL sim_count got %h required 10", kbdIf.cpu_rdata);
    end
    for (int i = 1; i < 17; i++) begin
      readReg(2'd0);
      checks++;
      if (kbdIf.cpu_rdata !== ((i == 16) ? 8'h71 : 8'h40 + 8'(i))) begin
        errors++;
        $display("[TB] FAIL sim_drain%0d got %h required %h", i, kbdIf.cpu_rdata,
                 (i == 16) ? 8'h71 : 8'h40 + 8'(i));
      end
    end
    applyStimulus(1'b1, 8'h65, 1'b1, 2'd0);
    checks++;
    if (kbdIf.cpu_rdata !== 8'h00 || kbdIf.irq !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sim_empty_pop got %h/irq=%b required 00/1", kbdIf.cpu_rdata, kbdIf.irq);
    end
    readReg(2'd2);
    checks++;
    if (kbdIf.cpu_rdata !== 8'h01) begin
      errors++;
      $display("[TB] FAIL sim_empty_count got %h required 01", kbdIf.cpu_rdata);
    end
    readReg(2'd0);
    checks++;
    if (kbdIf.cpu_rdata !== 8'h65) begin
      errors++;
      $display("[TB] FAIL sim_empty_data got %h required 65", kbdIf.cpu_rdata);
    end
  endtask

  task automatic test_wrap();
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 10; i++) begin
        pushKey(8'h60 + 8'(pass * 16 + i));
      end
      for (int i = 0; i < 10; i++) begin
        readReg(2'd0);
        checks++;
        if (kbdIf.cpu_rdata !== 8'h60 + 8'(pass * 16 + i)) begin
          errors++;
          $display("[TB] FAIL wrap_p%0d_%0d got %h required %h", pass, i,
                   kbdIf.cpu_rdata, 8'h60 + 8'(pass * 16 + i));
        end
      end
    end
    checks++;
    if (kbdIf.irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wrap_irq got %b required 0", kbdIf.irq);
    end
  endtask

  task automatic test_backspace();
    logic [7:0] expCount;
    logic [7:0] expPops [3];
`ifdef KBD_BACKSPACE_EN
    expCount = 8'h01;
    expPops  = '{8'h61, 8'h00, 8'h00};
`else
    expCount = 8'h03;
    expPops  = '{8'h61, 8'h62, 8'h08};
`endif
    pushKey(8'h61);
    pushKey(8'h62);
    pushKey(ASCII_BS);
    readReg(2'd2);
    checks++;
    if (kbdIf.cpu_rdata !== expCount) begin
      errors++;
      $display("[TB] FAIL bs_count got %h required %h", kbdIf.cpu_rdata, expCount);
    end
    for (int i = 0; i < 3; i++) begin
      readReg(2'd0);
      checks++;
      if (kbdIf.cpu_rdata !== expPops[i]) begin
        errors++;
        $display("[TB] FAIL bs_pop%0d got %h required %h", i, kbdIf.cpu_rdata, expPops[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    pushKey(8'h31);
    pushKey(8'h32);
    pushKey(8'h33);
    readReg(2'd2);
    checks++;
    if (kbdIf.cpu_rdata !== 8'h03) begin
      errors++;
      $display("[TB] FAIL arst_pre_count got %h required 03", kbdIf.cpu_rdata);
    end
    #2;
    clr = 1'b1;
    #1;
    checks++;
    if (kbdIf.irq !== 1'b0 || kbdIf.full !== 1'b0 || kbdIf.cpu_rdata !== 8'h00) begin
      errors++;
      $display("[TB] FAIL arst_immediate irq=%b full=%b rdata=%h required 0/0/00",
               kbdIf.irq, kbdIf.full, kbdIf.cpu_rdata);
    end
    @(negedge clk);
    clr = 1'b0;
    readReg(2'd2);
    checks++;
    if (kbdIf.cpu_rdata !== 8'h00) begin
      errors++;
      $display("[TB] FAIL arst_count got %h required 00", kbdIf.cpu_rdata);
    end
    readReg(2'd0);
    checks++;
    if (kbdIf.cpu_rdata !== 8'h00) begin
      errors++;
      $display("[TB] FAIL arst_pop got %h required 00", kbdIf.cpu_rdata);
    end
  endtask

  // Run every scenario in order and report the totals
  initial begin
    checks          = 0;
    errors          = 0;
    clr             = 1'b1;
    kbdIf.key_valid = 1'b0;
    kbdIf.key_ascii = 8'h00;
    kbdIf.cpu_rd    = 1'b0;
    kbdIf.cpu_addr  = 2'd0;
    test_reset();
    test_push_pop();
    test_full_overflow();
    test_status_sequence();
    test_simultaneous();
    test_wrap();
    test_backspace();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
